// File: rtl/rot_row_sched.sv
// Write-side scheduler for a 4-row circular line buffer: generates write addresses,
// counts completed rows and advances the read base on each reader release.
module rot_row_sched #(
  parameter int ROW_LEN = 8,
  parameter int CW      = $clog2(ROW_LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          pix_valid,
  output logic          pix_ready,
  output logic [1:0]    wr_row,
  output logic [CW-1:0] wr_col,
  output logic          wr_en,
  output logic          row_done,
  output logic [1:0]    base,
  output logic          rows_ready,
  input  logic          rd_done
);

  localparam logic [CW-1:0] LAST_COL = CW'(ROW_LEN - 1);

  typedef enum logic {FILL, FULL} mode_e;

  mode_e         mode;
  logic [1:0]    wr_row_q, wr_row_d;
  logic [1:0]    base_q, base_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [CW-1:0] wr_col_q, wr_col_d;
  logic          row_done_q, row_done_d;
  logic          rows_ready_q, rows_ready_d;
  logic          at_last, accept, row_end, rd_take;

  // Stall only the last pixel of the fourth row; a release always comes from registers.
  always_comb begin
    mode      = (cnt_q == 2'd3) ? FULL : FILL;
    at_last   = (wr_col_q == LAST_COL);
    pix_ready = !((mode == FULL) && at_last);
    accept    = pix_valid && pix_ready;
    row_end   = accept && at_last;
    rd_take   = rd_done && (mode == FULL);
  end

  always_comb begin
    wr_row_d     = wr_row_q;
    wr_col_d     = wr_col_q;
    base_d       = base_q;
    cnt_d        = cnt_q;
    row_done_d   = 1'b0;
    if (clr) begin
      wr_row_d = 2'd0;
      wr_col_d = '0;
      base_d   = 2'd0;
      cnt_d    = 2'd0;
    end else begin
      if (accept) begin
        if (at_last) begin
          wr_col_d = '0;
          wr_row_d = wr_row_q + 2'd1;
        end else begin
          wr_col_d = wr_col_q + CW'(1);
        end
      end
      if (rd_take) begin
        base_d = base_q + 2'd1;
      end
      // Row completion and a taken release never coincide: FULL stalls the last pixel.
      case ({row_end, rd_take})
        2'b10:   cnt_d = cnt_q + 2'd1;
        2'b01:   cnt_d = cnt_q - 2'd1;
        default: cnt_d = cnt_q;
      endcase
      row_done_d = row_end;
    end
    rows_ready_d = (cnt_d == 2'd3);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_row_q     <= 2'd0;
      wr_col_q     <= '0;
      base_q       <= 2'd0;
      cnt_q        <= 2'd0;
      row_done_q   <= 1'b0;
      rows_ready_q <= 1'b0;
    end else begin
      wr_row_q     <= wr_row_d;
      wr_col_q     <= wr_col_d;
      base_q       <= base_d;
      cnt_q        <= cnt_d;
      row_done_q   <= row_done_d;
      rows_ready_q <= rows_ready_d;
    end
  end

  assign wr_row     = wr_row_q;
  assign wr_col     = wr_col_q;
  assign wr_en      = accept;
  assign row_done   = row_done_q;
  assign base       = base_q;
  assign rows_ready = rows_ready_q;

endmodule

// File: tb/tb_rot_row_sched.sv
// Scoreboard bench for rot_row_sched with ROW_LEN=4: expected write addresses are
// queued as pixels are offered and popped whenever the DUT asserts wr_en.
module tb_rot_row_sched;

  localparam int ROW_LEN = 4;
  localparam int CW      = 2;

  logic          clk;
  logic          rst;
  logic          clr;
  logic          pix_valid;
  logic          pix_ready;
  logic [1:0]    wr_row;
  logic [CW-1:0] wr_col;
  logic          wr_en;
  logic          row_done;
  logic [1:0]    base;
  logic          rows_ready;
  logic          rd_done;

  int total = 0;
  int bad   = 0;
  logic [1+CW:0] exp_q[$];

  rot_row_sched #(.ROW_LEN(ROW_LEN), .CW(CW)) dut (
    .clk(clk), .rst(rst), .clr(clr), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .wr_row(wr_row), .wr_col(wr_col), .wr_en(wr_en), .row_done(row_done),
    .base(base), .rows_ready(rows_ready), .rd_done(rd_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Address scoreboard plus the rows_ready/wr_row relationship, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("[TB] FAIL addr_unexpected: got row=%0d col=%0d want no write", wr_row, wr_col);
        end else begin
          logic [1+CW:0] e;
          e = exp_q.pop_front();
          if ({wr_row, wr_col} !== e) begin
            bad++;
            $display("[TB] FAIL addr: got row=%0d col=%0d want row=%0d col=%0d",
                     wr_row, wr_col, e[1+CW:CW], e[CW-1:0]);
          end
        end
      end
      if (rows_ready) begin
        total++;
        if (wr_row !== 2'(base + 2'd3)) begin
          bad++;
          $display("[TB] FAIL full_wr_row: got %0d want %0d", wr_row, 2'(base + 2'd3));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_row(input int row, input bit rd_last);
    for (int c = 0; c < ROW_LEN; c++) begin
      pix_valid = 1'b1;
      rd_done   = rd_last && (c == ROW_LEN - 1);
      exp_q.push_back({2'(row), CW'(c)});
      tick();
    end
    pix_valid = 1'b0;
    rd_done   = 1'b0;
  endtask

  task automatic flush();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    #3;
    total++; if (wr_row !== 2'd0) begin bad++; $display("[TB] FAIL rst_wr_row: got %0d want 0", wr_row); end
    total++; if (wr_col !== 2'd0) begin bad++; $display("[TB] FAIL rst_wr_col: got %0d want 0", wr_col); end
    total++; if (base !== 2'd0) begin bad++; $display("[TB] FAIL rst_base: got %0d want 0", base); end
    total++; if (row_done !== 1'b0) begin bad++; $display("[TB] FAIL rst_row_done: got %0b want 0", row_done); end
    total++; if (rows_ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_rows_ready: got %0b want 0", rows_ready); end
    total++; if (pix_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_pix_ready: got %0b want 1", pix_ready); end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 3 * ROW_LEN; i++) begin
      pix_valid = 1'b1;
      exp_q.push_back({2'(i / ROW_LEN), CW'(i % ROW_LEN)});
      tick();
      total++;
      if (row_done !== ((i % ROW_LEN) == ROW_LEN - 1)) begin
        bad++; $display("[TB] FAIL fill_row_done[%0d]: got %0b want %0b", i, row_done, (i % ROW_LEN) == ROW_LEN - 1);
      end
      total++;
      if (rows_ready !== (i == 3 * ROW_LEN - 1)) begin
        bad++; $display("[TB] FAIL fill_rows_ready[%0d]: got %0b want %0b", i, rows_ready, i == 3 * ROW_LEN - 1);
      end
    end
    pix_valid = 1'b0;
    total++; if (base !== 2'd0) begin bad++; $display("[TB] FAIL fill_base: got %0d want 0", base); end
    total++; if (wr_row !== 2'd3) begin bad++; $display("[TB] FAIL fill_wr_row: got %0d want 3", wr_row); end
    total++; if (wr_col !== 2'd0) begin bad++; $display("[TB] FAIL fill_wr_col: got %0d want 0", wr_col); end
  endtask

  task automatic test_stall();
    for (int c = 0; c < ROW_LEN - 1; c++) begin
      pix_valid = 1'b1;
      exp_q.push_back({2'd3, CW'(c)});
      tick();
    end
    total++; if (wr_col !== 2'(ROW_LEN - 1)) begin bad++; $display("[TB] FAIL stall_col: got %0d want %0d", wr_col, ROW_LEN - 1); end
    for (int k = 0; k <= 10; k++) begin
      total++;
      if (pix_ready !== 1'b0 || wr_en !== 1'b0) begin
        bad++; $display("[TB] FAIL stall_hold[%0d]: got ready=%0b en=%0b want 0/0", k, pix_ready, wr_en);
      end
      if (k < 10) tick();
    end
  endtask

  task automatic test_release();
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    total++; if (base !== 2'd1) begin bad++; $display("[TB] FAIL rel_base: got %0d want 1", base); end
    total++; if (rows_ready !== 1'b0) begin bad++; $display("[TB] FAIL rel_rows_ready: got %0b want 0", rows_ready); end
    total++; if (pix_ready !== 1'b1) begin bad++; $display("[TB] FAIL rel_pix_ready: got %0b want 1", pix_ready); end
    exp_q.push_back({2'd3, CW'(ROW_LEN - 1)});
    tick();
    pix_valid = 1'b0;
    total++; if (rows_ready !== 1'b1) begin bad++; $display("[TB] FAIL rel_refull: got %0b want 1", rows_ready); end
    total++; if (wr_row !== 2'd0) begin bad++; $display("[TB] FAIL rel_wrap_row: got %0d want 0", wr_row); end
    total++; if (row_done !== 1'b1) begin bad++; $display("[TB] FAIL rel_row_done: got %0b want 1", row_done); end
  endtask

  task automatic test_ignored_release();
    flush();
    total++; if (row_done !== 1'b0 || rows_ready !== 1'b0) begin bad++; $display("[TB] FAIL clr_flags: got rd=%0b rr=%0b want 0/0", row_done, rows_ready); end
    total++; if (wr_row !== 2'd0 || base !== 2'd0) begin bad++; $display("[TB] FAIL clr_ptrs: got row=%0d base=%0d want 0/0", wr_row, base); end
    send_row(0, 1'b0);
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    total++; if (base !== 2'd0) begin bad++; $display("[TB] FAIL ign_base: got %0d want 0", base); end
    total++; if (wr_row !== 2'd1) begin bad++; $display("[TB] FAIL ign_wr_row: got %0d want 1", wr_row); end
    send_row(1, 1'b0);
    total++; if (rows_ready !== 1'b0) begin bad++; $display("[TB] FAIL ign_two_rows: got %0b want 0", rows_ready); end
    send_row(2, 1'b1);
    total++; if (rows_ready !== 1'b1) begin bad++; $display("[TB] FAIL ign_coincide_ready: got %0b want 1", rows_ready); end
    total++; if (base !== 2'd0) begin bad++; $display("[TB] FAIL ign_coincide_base: got %0d want 0", base); end
    total++; if (wr_row !== 2'd3) begin bad++; $display("[TB] FAIL ign_coincide_row: got %0d want 3", wr_row); end
  endtask

  task automatic test_wrap_sweep();
    int releases;
    releases = 0;
    flush();
    for (int r = 0; r < 40; r++) begin
      send_row(r, 1'b0);
      total++; if (row_done !== 1'b1) begin bad++; $display("[TB] FAIL sweep_row_done[%0d]: got %0b want 1", r, row_done); end
      total++; if (rows_ready !== (r >= 2)) begin bad++; $display("[TB] FAIL sweep_ready[%0d]: got %0b want %0b", r, rows_ready, r >= 2); end
      total++; if (wr_row !== 2'(r + 1)) begin bad++; $display("[TB] FAIL sweep_wr_row[%0d]: got %0d want %0d", r, wr_row, 2'(r + 1)); end
      if (r >= 2) begin
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        releases++;
        total++; if (base !== 2'(releases)) begin bad++; $display("[TB] FAIL sweep_base[%0d]: got %0d want %0d", r, base, 2'(releases)); end
        total++; if (rows_ready !== 1'b0) begin bad++; $display("[TB] FAIL sweep_drop[%0d]: got %0b want 0", r, rows_ready); end
      end
    end
  endtask

  task automatic test_reset_mid_row();
    flush();
    send_row(0, 1'b0);
    for (int c = 0; c < 2; c++) begin
      pix_valid = 1'b1;
      exp_q.push_back({2'd1, CW'(c)});
      tick();
    end
    pix_valid = 1'b0;
    total++; if (wr_row !== 2'd1 || wr_col !== 2'd2) begin bad++; $display("[TB] FAIL mid_pos: got %0d/%0d want 1/2", wr_row, wr_col); end
    #2 rst = 1'b1;
    #1;
    total++; if (wr_row !== 2'd0 || wr_col !== 2'd0) begin bad++; $display("[TB] FAIL arst_addr: got %0d/%0d want 0/0", wr_row, wr_col); end
    total++; if (base !== 2'd0 || row_done !== 1'b0 || rows_ready !== 1'b0) begin bad++; $display("[TB] FAIL arst_state: got b=%0d rd=%0b rr=%0b want 0", base, row_done, rows_ready); end
    total++; if (pix_ready !== 1'b1) begin bad++; $display("[TB] FAIL arst_ready: got %0b want 1", pix_ready); end
    tick();
    rst = 1'b0;
    pix_valid = 1'b1;
    exp_q.push_back({2'd0, CW'(0)});
    tick();
    pix_valid = 1'b0;
    total++; if (wr_col !== 2'd1) begin bad++; $display("[TB] FAIL arst_resume: got %0d want 1", wr_col); end

    flush();
    send_row(0, 1'b0);
    for (int c = 0; c < 2; c++) begin
      pix_valid = 1'b1;
      exp_q.push_back({2'd1, CW'(c)});
      tick();
    end
    clr = 1'b1;
    exp_q.push_back({2'd1, CW'(2)});
    #1;
    total++; if (wr_col !== 2'd2) begin bad++; $display("[TB] FAIL clr_before_edge: got %0d want 2", wr_col); end
    tick();
    clr = 1'b0;
    pix_valid = 1'b0;
    total++; if (wr_row !== 2'd0 || wr_col !== 2'd0) begin bad++; $display("[TB] FAIL clr_addr: got %0d/%0d want 0/0", wr_row, wr_col); end
    total++; if (base !== 2'd0 || row_done !== 1'b0 || rows_ready !== 1'b0) begin bad++; $display("[TB] FAIL clr_state: got b=%0d rd=%0b rr=%0b want 0", base, row_done, rows_ready); end
    total++; if (pix_ready !== 1'b1) begin bad++; $display("[TB] FAIL clr_ready: got %0b want 1", pix_ready); end
  endtask

  initial begin
    clr       = 1'b0;
    pix_valid = 1'b0;
    rd_done   = 1'b0;
    test_reset();
    test_fill();
    test_stall();
    test_release();
    test_ignored_release();
    test_wrap_sweep();
    test_reset_mid_row();
    tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("[TB] FAIL lost_pixels: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rot_row_sched.md
# rot_row_sched

Write-side scheduler for the 4-row circular line buffer whose read rows are selected by the rotating counter. It accepts a pixel stream, generates the write row/column address, and counts completed rows. Once three complete rows are held, it flags the read window as ready. On each read release it advances the 2-bit `base` that drives the read-side rotating counter, so the reader always sees rows `base`, `base+1` and `base+2` (mod 4) while the fourth row is being written.

## Interface
Parameters:
- `ROW_LEN`, default 8: pixels per row. Must be at least 2.
- `CW`, default `$clog2(ROW_LEN)`: column index width.

Ports:
- `clk`, input, 1: the only clock. All state updates on the rising edge.
- `rst`, input, 1: reset. Asynchronous and active-high.
- `clr`, input, 1: synchronous flush. Same effect as reset, applied at the clock edge.
- `pix_valid`, input, 1: a pixel is offered this cycle.
- `pix_ready`, output, 1: the scheduler can accept a pixel. A write occurs when `pix_valid && pix_ready`.
- `wr_row`, output, 2: row buffer index for the current write.
- `wr_col`, output, CW: column index for the current write.
- `wr_en`, output, 1: equals `pix_valid && pix_ready`. Combinational.
- `row_done`, output, 1: one-cycle pulse, the cycle after the last pixel of a row is written.
- `base`, output, 2: oldest held row. Feeds the read-side rotating counter.
- `rows_ready`, output, 1: three complete rows are held, so the read window is valid.
- `rd_done`, input, 1: the reader has finished with the current window and releases row `base`.

## Operation
- Internal state:
  - `cnt`, 2 bits, range 0..3: number of complete rows held.
  - Write pointer `wr_row`.
  - Column counter `wr_col`.
  - Read pointer `base`.
- Invariant: `wr_row == base + cnt` (mod 4) at all times.
- Modes are decoded from `cnt`:
  - FILL when `cnt < 3`.
  - FULL when `cnt == 3`.
- Reset values (both `rst` and `clr`):
  - `wr_row = 0`, `wr_col = 0`, `base = 0`, `cnt = 0`.
  - `row_done = 0`, `rows_ready = 0`.
  - `pix_ready = 1`.
- Accepted pixel with `wr_col < ROW_LEN-1`: `wr_col` increments.
- Accepted pixel with `wr_col == ROW_LEN-1` (row completes):
  - `wr_col` goes to 0.
  - `wr_row` goes to `wr_row+1`, wrapping 3 to 0.
  - `cnt` increments.
  - `row_done` is set for one cycle.
- `pix_ready = !(cnt == 3 && wr_col == ROW_LEN-1)`.
  - In FULL mode the fourth row can be written up to, but not including, its last pixel.
  - The stall holds until `rd_done` frees a row.
  - `pix_ready` depends only on registers. There is no combinational path from `rd_done`.
- `rd_done` in FULL mode:
  - `base` goes to `base+1`, wrapping 3 to 0.
  - `cnt` decrements.
- `rd_done` in FILL mode is ignored: no state change.
- Simultaneous row completion and `rd_done` can only occur with `cnt == 3` if the last pixel was not stalled, which cannot happen. Therefore, whenever both events coincide in FILL mode, only the row completion takes effect and `rd_done` is dropped.
- `rows_ready` is registered and equals `(cnt == 3)` as it stands after each clock edge.
- `clr` takes priority over all other inputs in the same cycle.

## Timing
- `wr_row`, `wr_col` and `wr_en` are valid in the same cycle as the accepted pixel. Addressing has zero latency.
- `row_done` and the `cnt` increment are visible one cycle after the last pixel is accepted. `rows_ready` rises in that same cycle when `cnt` reaches 3.
- `base` advances one cycle after `rd_done`. `rows_ready` falls in that same cycle, since `cnt` drops to 2.
- Stall release:
  - `rd_done` in cycle N.
  - `cnt == 2` and `pix_ready == 1` in cycle N+1.
  - The last pixel can be accepted in cycle N+1.
- `rst` asserted mid-row: outputs return to their reset values immediately. Partial row data is discarded.
- Throughput: one pixel per cycle, except for stalls.

## Test plan
Run with `ROW_LEN = 4`.
- **Reset and initial fill:** stream 12 pixels back-to-back.
  - Required: `wr_row`/`wr_col` step (0,0)..(0,3),(1,0)..(2,3).
  - Required: `row_done` pulses at cycles 4, 8 and 12.
  - Required: `rows_ready` is 1 after the 12th pixel, with `base == 0`.
- **Stall:** continue streaming without `rd_done`.
  - Required: row 3 columns 0..2 are accepted.
  - Required: `pix_ready` goes to 0 at `wr_col == 3` and stays 0 for 10 idle cycles.
- **Release:** assert `rd_done` for one cycle.
  - Required next cycle: `base == 1`, `rows_ready == 0`, `pix_ready == 1`.
  - Required: the pending pixel is written to (3,3).
  - Required: the cycle after that, `rows_ready == 1` and `wr_row == 0`, showing wrap-around.
- **Ignored release:** assert `rd_done` with `cnt == 1`.
  - Required: `base` and `cnt` unchanged.
- **Wrap sweep:** run 40 rows with `rd_done` pulsed after each `row_done` once `rows_ready` is set.
  - Required: `base` cycles 0,1,2,3,0,...
  - Required: `wr_row == base + 3` (mod 4) whenever `rows_ready` is 1.
  - Required: no accepted pixel is lost.
- **Reset mid-row:** assert `rst` asynchronously at `wr_col == 2` of row 1.
  - Required immediately: all outputs at their reset values and `pix_ready == 1`.
  - Repeat the same check using `clr`, which takes effect at the next edge.
